// File: rtl/output_writeback.sv
// Result writeback: captures per-PE results into one pending slot per PE, drains them
// one per cycle through a round-robin arbiter into the result memory, and signals
// completion once N*N results have been written.
module output_writeback #(
    parameter int unsigned ROWS         = 4,
    parameter int unsigned COLS         = 4,
    parameter int unsigned MAX_N        = 16,
    parameter int unsigned N_BITS       = $clog2(MAX_N + 1),
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned ADDR_BITS    = $clog2(MAX_N * MAX_N),
    parameter int unsigned STALL_THRESH = 8
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 start,
    input  logic [N_BITS-1:0]                    mat_size,
    input  logic [ROWS*COLS-1:0]                 pe_valid,
    input  logic [ROWS*COLS-1:0][N_BITS-1:0]     pe_row,
    input  logic [ROWS*COLS-1:0][N_BITS-1:0]     pe_col,
    input  logic [ROWS*COLS-1:0][DATA_W-1:0]     pe_data,
    output logic                                 stall,
    output logic                                 mem_we,
    output logic [ADDR_BITS-1:0]                 mem_addr,
    output logic [DATA_W-1:0]                    mem_wdata,
    output logic                                 busy,
    output logic                                 done,
    output logic                                 overflow_err
);

    localparam int unsigned NPE   = ROWS * COLS;
    localparam int unsigned PTR_W = (NPE > 1) ? $clog2(NPE) : 1;
    localparam int unsigned CNT_W = $clog2(MAX_N * MAX_N + 1);
    localparam int unsigned OCC_W = $clog2(NPE + 1);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StRun  = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    logic [1:0]                   state_q, state_d;
    logic [N_BITS-1:0]            n_q, n_d;
    logic [CNT_W-1:0]             wcount_q, wcount_d;
    logic [PTR_W-1:0]             ptr_q, ptr_d;
    logic [NPE-1:0]               occ_q, occ_d;
    logic [NPE-1:0][N_BITS-1:0]   row_q, row_d;
    logic [NPE-1:0][N_BITS-1:0]   col_q, col_d;
    logic [NPE-1:0][DATA_W-1:0]   data_q, data_d;
    logic                         ovf_q, ovf_d;
    logic                         stall_q, stall_d;
    logic                         we_q, we_d;
    logic [ADDR_BITS-1:0]         addr_q, addr_d;
    logic [DATA_W-1:0]            wdata_q, wdata_d;

    logic                         start_ok;
    logic [CNT_W-1:0]             n_sq;
    logic [CNT_W-1:0]             committed;
    logic                         gnt_valid;
    logic [PTR_W-1:0]             gnt_idx;
    int unsigned                  scan_idx;
    logic [OCC_W-1:0]             occ_cnt;

    assign start_ok  = (state_q == StIdle) && start && (mat_size != '0) &&
                       (32'(mat_size) <= MAX_N);
    assign n_sq      = CNT_W'(n_q) * CNT_W'(n_q);
    // Writes already issued: counted ones plus the one on the memory port now.
    assign committed = wcount_q + CNT_W'(we_q);

    // Round-robin grant: first occupied slot at or after the pointer, wrapping.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        scan_idx  = 0;
        for (int i = 0; i < NPE; i++) begin
            scan_idx = (int'(ptr_q) + i) % NPE;
            if (!gnt_valid && occ_q[PTR_W'(scan_idx)]) begin
                gnt_valid = 1'b1;
                gnt_idx   = PTR_W'(scan_idx);
            end
        end
        // Never issue more than N*N writes, so duplicates cannot overrun the count.
        if (state_q != StRun || committed >= n_sq) begin
            gnt_valid = 1'b0;
        end
    end

    // Control FSM and write counter.
    always_comb begin
        state_d  = state_q;
        n_d      = n_q;
        wcount_d = wcount_q;
        case (state_q)
            StIdle: begin
                if (start_ok) begin
                    state_d  = StRun;
                    n_d      = mat_size;
                    wcount_d = '0;
                end
            end
            StRun: begin
                if (we_q) begin
                    wcount_d = wcount_q + CNT_W'(1);
                    if (wcount_d == n_sq) begin
                        state_d = StDone;
                    end
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Slot capture/drain, overrun detection and arbiter pointer.
    always_comb begin
        occ_d  = occ_q;
        row_d  = row_q;
        col_d  = col_q;
        data_d = data_q;
        ovf_d  = ovf_q;
        ptr_d  = ptr_q;
        if (state_q == StRun) begin
            if (gnt_valid) begin
                occ_d[gnt_idx] = 1'b0;
                ptr_d = (gnt_idx == PTR_W'(NPE - 1)) ? '0 : gnt_idx + 1'b1;
            end
            for (int k = 0; k < NPE; k++) begin
                // Out-of-range coordinates are edge-block padding and vanish silently.
                if (pe_valid[k] && (pe_row[k] < n_q) && (pe_col[k] < n_q)) begin
                    if (occ_q[k] && !(gnt_valid && gnt_idx == PTR_W'(k))) begin
                        ovf_d = 1'b1;
                    end else begin
                        occ_d[k]  = 1'b1;
                        row_d[k]  = pe_row[k];
                        col_d[k]  = pe_col[k];
                        data_d[k] = pe_data[k];
                    end
                end
            end
        end
        if (start_ok) begin
            occ_d = '0;
            ovf_d = 1'b0;
        end
        // Leftovers (duplicate coordinates) are discarded once the matrix is complete.
        if (state_d == StDone) begin
            occ_d = '0;
        end
    end

    // Registered memory port and stall.
    always_comb begin
        we_d    = gnt_valid;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        if (gnt_valid) begin
            addr_d  = ADDR_BITS'(row_q[gnt_idx]) * ADDR_BITS'(n_q) +
                      ADDR_BITS'(col_q[gnt_idx]);
            wdata_d = data_q[gnt_idx];
        end
        occ_cnt = '0;
        for (int k = 0; k < NPE; k++) begin
            occ_cnt = occ_cnt + OCC_W'(occ_d[k]);
        end
        stall_d = (state_d != StIdle) && (32'(occ_cnt) >= STALL_THRESH);
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            n_q      <= '0;
            wcount_q <= '0;
            ptr_q    <= '0;
            occ_q    <= '0;
            row_q    <= '0;
            col_q    <= '0;
            data_q   <= '0;
            ovf_q    <= 1'b0;
            stall_q  <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            n_q      <= n_d;
            wcount_q <= wcount_d;
            ptr_q    <= ptr_d;
            occ_q    <= occ_d;
            row_q    <= row_d;
            col_q    <= col_d;
            data_q   <= data_d;
            ovf_q    <= ovf_d;
            stall_q  <= stall_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
        end
    end

    assign stall        = stall_q;
    assign mem_we       = we_q;
    assign mem_addr     = addr_q;
    assign mem_wdata    = wdata_q;
    assign busy         = (state_q != StIdle);
    assign done         = (state_q == StDone);
    assign overflow_err = ovf_q;

endmodule

// File: tb/tb_output_writeback.sv
// Directed self-checking bench for output_writeback.
module tb_output_writeback;

    localparam int N_BITS    = 5;
    localparam int DATA_W    = 32;
    localparam int ADDR_BITS = 8;
    localparam int NPE       = 16;

    logic                             clk = 1'b0;
    logic                             reset;
    logic                             start;
    logic [N_BITS-1:0]                mat_size;
    logic [NPE-1:0]                   pe_valid;
    logic [NPE-1:0][N_BITS-1:0]       pe_row;
    logic [NPE-1:0][N_BITS-1:0]       pe_col;
    logic [NPE-1:0][DATA_W-1:0]       pe_data;
    logic                             stall;
    logic                             mem_we;
    logic [ADDR_BITS-1:0]             mem_addr;
    logic [DATA_W-1:0]                mem_wdata;
    logic                             busy;
    logic                             done;
    logic                             overflow_err;

    int errors = 0;
    int checks = 0;

    output_writeback dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .mat_size     (mat_size),
        .pe_valid     (pe_valid),
        .pe_row       (pe_row),
        .pe_col       (pe_col),
        .pe_data      (pe_data),
        .stall        (stall),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .busy         (busy),
        .done         (done),
        .overflow_err (overflow_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_pe();
        pe_valid = '0;
        pe_row   = '0;
        pe_col   = '0;
        pe_data  = '0;
    endtask

    task automatic set_pe(input int k, input int row, input int col, input int data);
        pe_valid[k] = 1'b1;
        pe_row[k]   = N_BITS'(row);
        pe_col[k]   = N_BITS'(col);
        pe_data[k]  = DATA_W'(data);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, ".stall"},     64'(stall),        64'(0));
        chk({tag, ".mem_we"},    64'(mem_we),       64'(0));
        chk({tag, ".mem_addr"},  64'(mem_addr),     64'(0));
        chk({tag, ".mem_wdata"}, 64'(mem_wdata),    64'(0));
        chk({tag, ".busy"},      64'(busy),         64'(0));
        chk({tag, ".done"},      64'(done),         64'(0));
        chk({tag, ".ovf"},       64'(overflow_err), 64'(0));
    endtask

    initial begin
        int nwr;
        int ndone;
        int nwe;
        int exp_d[9];
        exp_d = '{0, 1, 2, 4, 5, 6, 8, 9, 10};

        reset    = 1'b1;
        start    = 1'b0;
        mat_size = '0;
        clear_pe();
        tick();
        tick();
        chk_reset_outputs("rst");
        reset = 1'b0;
        tick();

        // Full 4x4 burst: 16 in-order writes, stall while >= 8 pending.
        start = 1'b1; mat_size = 5'd4;
        tick();
        start = 1'b0;
        chk("r20.busy", 64'(busy), 64'(1));
        for (int k = 0; k < 16; k++) set_pe(k, k / 4, k % 4, k);
        tick();
        clear_pe();
        chk("r20.stall0", 64'(stall), 64'(1));
        chk("r20.we0", 64'(mem_we), 64'(0));
        for (int k = 1; k <= 16; k++) begin
            tick();
            chk($sformatf("r20.we[%0d]", k), 64'(mem_we), 64'(1));
            chk($sformatf("r20.addr[%0d]", k), 64'(mem_addr), 64'(k - 1));
            chk($sformatf("r20.data[%0d]", k), 64'(mem_wdata), 64'(k - 1));
            chk($sformatf("r20.stall[%0d]", k), 64'(stall), 64'((16 - k) >= 8));
            chk($sformatf("r20.done[%0d]", k), 64'(done), 64'(0));
        end
        tick();
        chk("r20.done", 64'(done), 64'(1));
        chk("r20.busy_done", 64'(busy), 64'(1));
        chk("r20.we_done", 64'(mem_we), 64'(0));
        tick();
        chk("r20.done_off", 64'(done), 64'(0));
        chk("r20.idle", 64'(busy), 64'(0));

        // N=3 with a full 4x4 block: row/col 3 entries are padding.
        start = 1'b1; mat_size = 5'd3;
        tick();
        start = 1'b0;
        for (int k = 0; k < 16; k++) set_pe(k, k / 4, k % 4, k);
        tick();
        clear_pe();
        nwr = 0;
        ndone = 0;
        for (int c = 0; c < 25; c++) begin
            if (mem_we) begin
                if (nwr < 9) begin
                    chk($sformatf("r21.addr[%0d]", nwr), 64'(mem_addr), 64'(nwr));
                    chk($sformatf("r21.data[%0d]", nwr), 64'(mem_wdata), 64'(exp_d[nwr]));
                end
                nwr++;
            end
            if (done) ndone++;
            tick();
        end
        chk("r21.nwrites", 64'(nwr), 64'(9));
        chk("r21.ndone", 64'(ndone), 64'(1));
        chk("r21.ovf", 64'(overflow_err), 64'(0));
        chk("r21.idle", 64'(busy), 64'(0));

        // Overrun on pending slot 5: first data kept, second never written.
        start = 1'b1; mat_size = 5'd4;
        tick();
        start = 1'b0;
        for (int k = 0; k < 6; k++) set_pe(k, k / 4, k % 4, 100 + k);
        tick();
        clear_pe();
        chk("r22.we0", 64'(mem_we), 64'(0));
        set_pe(5, 1, 1, 999);
        tick();
        clear_pe();
        chk("r22.ovf", 64'(overflow_err), 64'(1));
        chk("r22.we1", 64'(mem_we), 64'(1));
        chk("r22.addr1", 64'(mem_addr), 64'(0));
        chk("r22.data1", 64'(mem_wdata), 64'(100));
        for (int k = 2; k <= 8; k++) begin
            tick();
            chk($sformatf("r22.we[%0d]", k), 64'(mem_we), 64'(k <= 6));
            if (k <= 6) begin
                chk($sformatf("r22.addr[%0d]", k), 64'(mem_addr), 64'(k - 1));
                chk($sformatf("r22.data[%0d]", k), 64'(mem_wdata), 64'(100 + k - 1));
            end
        end

        // Reset mid-run with 6 slots pending, start and pe_valid also asserted.
        for (int k = 6; k < 12; k++) set_pe(k, k / 4, k % 4, 100 + k);
        tick();
        clear_pe();
        chk("r24.ovf_sticky", 64'(overflow_err), 64'(1));
        chk("r24.busy_pre", 64'(busy), 64'(1));
        reset = 1'b1; start = 1'b1; mat_size = 5'd4;
        for (int k = 0; k < 16; k++) set_pe(k, 0, 0, 55);
        tick();
        reset = 1'b0; start = 1'b0;
        clear_pe();
        chk_reset_outputs("r24");
        nwe = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (mem_we || busy) nwe++;
        end
        chk("r24.quiet", 64'(nwe), 64'(0));

        // Slot 0 drained and reloaded in the same cycle.
        start = 1'b1; mat_size = 5'd4;
        tick();
        start = 1'b0;
        set_pe(0, 0, 0, 7);
        tick();
        clear_pe();
        set_pe(0, 0, 2, 77);
        tick();
        clear_pe();
        chk("r23.we1", 64'(mem_we), 64'(1));
        chk("r23.addr1", 64'(mem_addr), 64'(0));
        chk("r23.data1", 64'(mem_wdata), 64'(7));
        chk("r23.ovf1", 64'(overflow_err), 64'(0));
        tick();
        chk("r23.we2", 64'(mem_we), 64'(1));
        chk("r23.addr2", 64'(mem_addr), 64'(2));
        chk("r23.data2", 64'(mem_wdata), 64'(77));
        tick();
        chk("r23.we3", 64'(mem_we), 64'(0));

        // Start while busy is ignored: N stays 4, so (3,3) is still in range.
        start = 1'b1; mat_size = 5'd2;
        tick();
        start = 1'b0;
        chk("r25.busy_start", 64'(busy), 64'(1));
        set_pe(3, 3, 3, 5);
        tick();
        clear_pe();
        tick();
        chk("r25.we", 64'(mem_we), 64'(1));
        chk("r25.addr", 64'(mem_addr), 64'(15));
        chk("r25.data", 64'(mem_wdata), 64'(5));
        chk("r25.ovf", 64'(overflow_err), 64'(0));
        reset = 1'b1;
        tick();
        reset = 1'b0;

        // Illegal sizes are ignored; MAX_N is accepted.
        start = 1'b1; mat_size = 5'd0;
        tick();
        start = 1'b0;
        chk("r25.size0", 64'(busy), 64'(0));
        start = 1'b1; mat_size = 5'd17;
        tick();
        start = 1'b0;
        chk("r25.size17", 64'(busy), 64'(0));
        start = 1'b1; mat_size = 5'd16;
        tick();
        start = 1'b0;
        chk("r25.size16", 64'(busy), 64'(1));
        reset = 1'b1;
        tick();
        reset = 1'b0;

        // 1x1 matrix with a negative value and an out-of-range neighbour.
        start = 1'b1; mat_size = 5'd1;
        tick();
        start = 1'b0;
        set_pe(6, 0, 0, -5);
        set_pe(7, 0, 1, 9);
        tick();
        clear_pe();
        tick();
        chk("n1.we", 64'(mem_we), 64'(1));
        chk("n1.addr", 64'(mem_addr), 64'(0));
        chk("n1.data", 64'(mem_wdata), 64'(32'hFFFF_FFFB));
        tick();
        chk("n1.done", 64'(done), 64'(1));
        chk("n1.we_done", 64'(mem_we), 64'(0));
        tick();
        chk("n1.idle", 64'(busy), 64'(0));
        chk("n1.done_off", 64'(done), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
